// File: rtl/i2c_color_receiver.sv
// I2C write-only target that reassembles a 10-byte color-sensor frame into five
// 16-bit channel words, committing them with a single-cycle valid pulse on STOP.
module i2c_color_receiver #(
  parameter logic [6:0]  ADDRESS     = 7'h29,
  parameter int unsigned FRAME_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        endian,
  output logic [15:0] clear_data,
  output logic [15:0] red_data,
  output logic [15:0] green_data,
  output logic [15:0] blue_data,
  output logic [15:0] infrared_data,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [3:0] FRAME_LEN = 4'(FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t      state_q;
  logic        sclMeta_q, sclSync_q, sclHist_q;
  logic        sdaMeta_q, sdaSync_q, sdaHist_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [3:0]  bitCnt_q;
  logic [3:0]  byteCnt_q;
  logic        endian_q;
  logic        ackDrive_q;
  logic        sdaOe_q;
  logic        busy_q;
  logic        frameValid_q;
  logic        frameError_q;
  logic [7:0]  shadow_q [FRAME_BYTES];
  logic [15:0] clear_q, red_q, green_q, blue_q, infrared_q;

  logic sclChg, sdaChg, sclRise, sclFall, startDet, stopDet;
  logic partialByte, shortFrame, abortDet, commitOk;

  // Bus idles high, so the synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclHist_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaHist_q <= 1'b1;
    end else begin
      sclMeta_q <= scl;
      sclSync_q <= sclMeta_q;
      sclHist_q <= sclSync_q;
      sdaMeta_q <= sda_in;
      sdaSync_q <= sdaMeta_q;
      sdaHist_q <= sdaSync_q;
    end
  end

  assign sclChg   = sclSync_q ^ sclHist_q;
  assign sdaChg   = sdaSync_q ^ sdaHist_q;
  assign sclRise  = sclChg & sclSync_q;
  assign sclFall  = sclChg & ~sclSync_q;
  // An SDA change that coincides with an SCL change is never a START/STOP.
  assign startDet = sdaChg & ~sclChg & sclSync_q & ~sdaSync_q;
  assign stopDet  = sdaChg & ~sclChg & sclSync_q & sdaSync_q;
  assign shift_d  = {shift_q[6:0], sdaSync_q};

  // The SCL rise that sets up a STOP/START shifts one bit, so one bit is not "mid-byte".
  assign partialByte = (state_q == DATA) && (bitCnt_q > 4'd1);
  assign shortFrame  = (byteCnt_q != 4'd0) && (byteCnt_q < FRAME_LEN);
  assign abortDet    = ((state_q == DATA) || (state_q == DATA_ACK)) && (partialByte || shortFrame);
  assign commitOk    = (state_q == DATA) && (byteCnt_q == FRAME_LEN) && (bitCnt_q <= 4'd1);

  function automatic logic [15:0] joinWord(input logic [7:0] first, input logic [7:0] second,
                                           input logic bigEnd);
    return bigEnd ? {first, second} : {second, first};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      byteCnt_q    <= '0;
      endian_q     <= 1'b0;
      ackDrive_q   <= 1'b0;
      sdaOe_q      <= 1'b0;
      busy_q       <= 1'b0;
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      clear_q      <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      infrared_q   <= '0;
      for (int i = 0; i < FRAME_BYTES; i++) shadow_q[i] <= '0;
    end else begin
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      if (startDet) begin
        if (abortDet) frameError_q <= 1'b1;
        state_q    <= ADDR;
        bitCnt_q   <= '0;
        byteCnt_q  <= '0;
        endian_q   <= endian;
        busy_q     <= 1'b1;
        sdaOe_q    <= 1'b0;
        ackDrive_q <= 1'b0;
      end else if (stopDet) begin
        if (commitOk) begin
          clear_q      <= joinWord(shadow_q[0], shadow_q[1], endian_q);
          red_q        <= joinWord(shadow_q[2], shadow_q[3], endian_q);
          green_q      <= joinWord(shadow_q[4], shadow_q[5], endian_q);
          blue_q       <= joinWord(shadow_q[6], shadow_q[7], endian_q);
          infrared_q   <= joinWord(shadow_q[8], shadow_q[9], endian_q);
          frameValid_q <= 1'b1;
        end else if (abortDet) begin
          frameError_q <= 1'b1;
        end
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        sdaOe_q    <= 1'b0;
        ackDrive_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (sclRise) begin
              shift_q <= shift_d;
              if (bitCnt_q == 4'd7) begin
                bitCnt_q <= '0;
                if ((shift_d[7:1] == ADDRESS) && !shift_d[0]) state_q <= ADDR_ACK;
                else state_q <= IGNORE;
              end else begin
                bitCnt_q <= bitCnt_q + 4'd1;
              end
            end
          end
          // First SCL fall after the 8th bit grabs SDA, the next one releases it.
          ADDR_ACK, DATA_ACK: begin
            if (sclFall) begin
              if (!ackDrive_q) begin
                sdaOe_q    <= 1'b1;
                ackDrive_q <= 1'b1;
              end else begin
                sdaOe_q    <= 1'b0;
                ackDrive_q <= 1'b0;
                bitCnt_q   <= '0;
                state_q    <= DATA;
              end
            end
          end
          DATA: begin
            if (sclRise) begin
              shift_q <= shift_d;
              if (bitCnt_q == 4'd7) begin
                bitCnt_q <= '0;
                if (byteCnt_q < FRAME_LEN) begin
                  shadow_q[byteCnt_q] <= shift_d;
                  byteCnt_q           <= byteCnt_q + 4'd1;
                  state_q             <= DATA_ACK;
                end else begin
                  frameError_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IGNORE;
                end
              end else begin
                bitCnt_q <= bitCnt_q + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe        = sdaOe_q;
  assign busy          = busy_q;
  assign frame_valid   = frameValid_q;
  assign frame_error   = frameError_q;
  assign clear_data    = clear_q;
  assign red_data      = red_q;
  assign green_data    = green_q;
  assign blue_data     = blue_q;
  assign infrared_data = infrared_q;

endmodule
